// File: rtl/div_ctrl.sv
// div_ctrl: restoring-divider sequencer for DIV/DIVU with pipeline stall and exception cancel.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips the iterations and finishes in one cycle.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_startE,
  input  logic               div_signedE,
  input  logic [WIDTH-1:0]   opaE,
  input  logic [WIDTH-1:0]   opbE,
  input  logic               cancel,
  output logic               div_stallE,
  output logic               div_readyE,
  output logic [2*WIDTH-1:0] hiloE
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, stateNext;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] rem, quo, divisor, dividendRaw, absA, absB, remStep, quoStep;
  logic [WIDTH:0] trial, diff;
  logic quoNeg, remNeg, divZero, start, lastStep, fastZero;
  logic [2*WIDTH-1:0] result;
`ifdef DIV_ZERO_FAST_EN
  assign fastZero = (opbE == '0);
`else
  assign fastZero = 1'b0;
`endif
  assign start = div_startE & ~cancel;
  assign lastStep = (state == BUSY) & ~cancel & (count == CW'(WIDTH-1));
  assign absA = (div_signedE & opaE[WIDTH-1]) ? -opaE : opaE;
  assign absB = (div_signedE & opbE[WIDTH-1]) ? -opbE : opbE;
  // rem < divisor holds between steps, so a borrow shows up in the extra top bit
  always_comb begin
    trial = {rem, quo[WIDTH-1]};
    diff = trial - {1'b0, divisor};
    remStep = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    quoStep = {quo[WIDTH-2:0], ~diff[WIDTH]};
    result = divZero ? {dividendRaw, {WIDTH{1'b1}}}
                     : {remNeg ? -remStep : remStep, quoNeg ? -quoStep : quoStep};
  end
  always_comb begin
    stateNext = state;
    div_stallE = 1'b0;
    div_readyE = 1'b0;
    unique case (state)
      IDLE: begin
        stateNext = start ? (fastZero ? DONE : BUSY) : IDLE;
        div_stallE = rst & start;
      end
      BUSY: begin
        stateNext = cancel ? IDLE : (lastStep ? DONE : BUSY);
        div_stallE = rst & ~cancel;
      end
      DONE: begin
        stateNext = IDLE;
        div_readyE = rst & ~cancel;
      end
      default: stateNext = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= stateNext;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      count <= '0;
      rem <= '0;
      quo <= '0;
      divisor <= '0;
      dividendRaw <= '0;
      quoNeg <= 1'b0;
      remNeg <= 1'b0;
      divZero <= 1'b0;
      hiloE <= '0;
    end else if (state == IDLE && start) begin
      count <= '0;
      rem <= '0;
      quo <= absA;
      divisor <= absB;
      dividendRaw <= opaE;
      quoNeg <= div_signedE & (opaE[WIDTH-1] ^ opbE[WIDTH-1]);
      remNeg <= div_signedE & opaE[WIDTH-1];
      divZero <= (opbE == '0);
      if (fastZero) hiloE <= {opaE, {WIDTH{1'b1}}};
    end else if (state == BUSY && !cancel) begin
      rem <= remStep;
      quo <= quoStep;
      count <= count + 1'b1;
      if (lastStep) hiloE <= result;
    end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed and random divides checked against an arithmetic reference model.
module tb_div_ctrl;
  localparam int W = 32;
  logic clk = 0, rst = 0, div_startE = 0, div_signedE = 0, cancel = 0;
  logic [W-1:0] opaE = 0, opbE = 0;
  logic div_stallE, div_readyE;
  logic [2*W-1:0] hiloE;
  int total = 0, bad = 0;
  logic [63:0] lastExp;

  div_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .div_startE(div_startE), .div_signedE(div_signedE),
    .opaE(opaE), .opbE(opbE), .cancel(cancel),
    .div_stallE(div_stallE), .div_readyE(div_readyE), .hiloE(hiloE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic [31:0] q, r;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    if (s) begin
      sa = a;
      sb = b;
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic int latency(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    return (b == 0) ? 1 : W + 1;
`else
    return (b == 0) ? W + 1 : W + 1;
`endif
  endfunction

  // Inputs for cycle 0 are already driven; operands are scrambled afterwards to mimic forwarding noise.
  task automatic run(input string tag, input logic [63:0] exp, input logic [31:0] b);
    int stalls = 0;
    int readyAt = -1;
    int lat = latency(b);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (div_stallE) stalls++;
      if (div_readyE) begin
        readyAt = c;
        break;
      end
      @(posedge clk); #1;
      opaE = $urandom;
      opbE = $urandom;
    end
    check({tag, " result"}, hiloE, exp);
    check({tag, " stalls"}, 64'(stalls), 64'(lat));
    check({tag, " readyAt"}, 64'(readyAt), 64'(lat));
    @(posedge clk); #1;
    div_startE = 0;
    @(negedge clk);
    check({tag, " after"}, {62'b0, div_readyE, div_stallE}, 64'b0);
    lastExp = exp;
  endtask

  task automatic go(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    div_startE = 1;
    div_signedE = s;
    opaE = a;
    opbE = b;
    run(tag, model(s, a, b), b);
  endtask

  initial begin
    int readies;
    logic s;
    logic [31:0] a, b;
    div_startE = 1;
    @(negedge clk);
    check("reset hilo", hiloE, 64'b0);
    check("reset flags", {62'b0, div_readyE, div_stallE}, 64'b0);
    @(posedge clk); #1;
    rst = 1;
    div_startE = 0;
    go("divu 100/7", 0, 100, 7);
    check("divu 100/7 literal", lastExp, {32'd2, 32'd14});
    go("div -7/2", 1, 32'hFFFF_FFF9, 2);
    go("div 7/-2", 1, 7, 32'hFFFF_FFFE);
    go("div ovf", 1, 32'h8000_0000, 32'hFFFF_FFFF);
    go("divu by 0", 0, 32'h1234_5678, 0);
    go("div by 0", 1, 32'h8000_0005, 0);
    @(posedge clk); #1;
    div_startE = 1;
    div_signedE = 0;
    opaE = 100;
    opbE = 7;
    repeat (11) @(posedge clk);
    #1 cancel = 1;
    @(negedge clk);
    check("cancel stall", {63'b0, div_stallE}, 64'b0);
    @(posedge clk); #1;
    cancel = 0;
    div_startE = 0;
    readies = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (div_readyE) readies++;
    end
    check("cancel no ready", 64'(readies), 64'b0);
    check("cancel hilo kept", hiloE, lastExp);
    go("divu 9/3", 0, 9, 3);
    @(posedge clk); #1;
    div_startE = 1;
    opaE = 100;
    opbE = 7;
    repeat (21) @(posedge clk);
    #1 rst = 0;
    #1;
    check("midreset hilo", hiloE, 64'b0);
    check("midreset flags", {62'b0, div_readyE, div_stallE}, 64'b0);
    opaE = 50;
    opbE = 5;
    @(posedge clk); #1;
    rst = 1;
    run("restart 50/5", {32'd0, 32'd10}, 5);
    for (int i = 0; i < 16; i++) begin
      s = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0: b = 0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      go($sformatf("rand%0d", i), s, a, b);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
